// File: rtl/music_pkg.sv
// Shared definitions for the square-wave audio blocks.
//   tone_state_e     : tone detector FSM states
//   CLK_HZ           : default system clock frequency
//   NOTE_A440_PERIOD : full period of A440 in CLK_HZ cycles (two equal half periods)
package music_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_TRACK  = 2'd2,
    ST_LOCKED = 2'd3
  } tone_state_e;

  localparam int CLK_HZ = 25_000_000;
  // Generators toggle every CLK_HZ/(2*f) cycles, so the full period is twice
  // the truncated half period: 2*28409 = 56818 at 25 MHz.
  localparam int NOTE_A440_PERIOD = 2 * (CLK_HZ / 880);

endpackage

// File: rtl/edge_sync.sv
// Three-flop synchronizer with a rising-edge strobe for an asynchronous
// 1-bit input.
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset, clears all flops
//   d     : asynchronous input
//   rise  : one-cycle pulse, high while the synchronized input has just gone 0->1
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // s1/s2 resolve metastability; s3 is only the delayed copy for edge detection.
  assign rise = s2 & ~s3;

endmodule

// File: rtl/tone_detector.sv
// Measures the full period of a square-wave input in clk cycles, locks when
// consecutive periods agree within TOL, and flags a locked tone whose period
// is within TOL of NOTE_PERIOD.
//   clk, rst_n   : clock, asynchronous active-low reset
//   speaker_in   : asynchronous square wave
//   period       : last measured period (held while idle)
//   period_valid : one-cycle strobe when period updates
//   locked       : FSM is in LOCKED
//   note_match   : locked and last period within TOL of NOTE_PERIOD
//   silence      : FSM is in IDLE (no tone)
// Handshake: period_valid is a strobe with no ready/backpressure; period,
// locked and note_match update on the strobe cycle and hold until the next.
module tone_detector
  import music_pkg::*;
#(
  parameter int PERIOD_W    = 17,
  parameter int MAX_PERIOD  = 131071,
  parameter int TOL         = 64,
  parameter int LOCK_COUNT  = 4,
  parameter int NOTE_PERIOD = NOTE_A440_PERIOD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                speaker_in,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                locked,
  output logic                note_match,
  output logic                silence
);

  localparam int MC_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam logic [PERIOD_W-1:0] MAX_C   = PERIOD_W'(MAX_PERIOD);
  localparam logic [PERIOD_W-1:0] NOTE_C  = PERIOD_W'(NOTE_PERIOD);
  localparam logic [PERIOD_W:0]   TOL_C   = (PERIOD_W+1)'(TOL);
  localparam logic [MC_W-1:0]     MC_LAST = MC_W'(LOCK_COUNT - 1);

  // One extra bit so the subtraction cannot wrap; the sign bit picks the magnitude.
  function automatic logic [PERIOD_W:0] abs_diff(input logic [PERIOD_W-1:0] a,
                                                 input logic [PERIOD_W-1:0] b);
    logic [PERIOD_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[PERIOD_W] ? (~d + (PERIOD_W+1)'(1)) : d;
  endfunction

  tone_state_e         state, state_n;
  logic [PERIOD_W-1:0] cnt, cnt_n;
  logic [PERIOD_W-1:0] prev, prev_n;
  logic [PERIOD_W-1:0] period_n;
  logic [MC_W-1:0]     match_cnt, match_n;
  logic                pv_n;
  logic                note_n;
  logic                rise;
  logic                timeout;
  logic                close;

  edge_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (speaker_in),
    .rise (rise)
  );

  // An edge arriving on the MAX_PERIOD cycle wins over the timeout.
  assign timeout = (state != ST_IDLE) && (cnt == MAX_C) && !rise;
  assign close   = (abs_diff(cnt, prev) <= TOL_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      prev         <= '0;
      match_cnt    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      note_match   <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      prev         <= prev_n;
      match_cnt    <= match_n;
      period       <= period_n;
      period_valid <= pv_n;
      note_match   <= note_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    prev_n   = prev;
    match_n  = match_cnt;
    period_n = period;
    pv_n     = 1'b0;

    // Hold on timeout so the idle counter never wraps past MAX_PERIOD.
    if (rise) begin
      cnt_n = PERIOD_W'(1);
    end else if (state != ST_IDLE && !timeout) begin
      cnt_n = cnt + PERIOD_W'(1);
    end

    case (state)
      ST_IDLE: begin
        if (rise) state_n = ST_ARMED;
      end
      ST_ARMED: begin
        if (rise) begin
          period_n = cnt;
          pv_n     = 1'b1;
          prev_n   = cnt;
          match_n  = '0;
          state_n  = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (rise) begin
          period_n = cnt;
          pv_n     = 1'b1;
          prev_n   = cnt;
          if (close) begin
            if (match_cnt == MC_LAST) begin
              state_n = ST_LOCKED;
              match_n = '0;
            end else begin
              match_n = match_cnt + MC_W'(1);
            end
          end else begin
            match_n = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (rise) begin
          period_n = cnt;
          pv_n     = 1'b1;
          prev_n   = cnt;
          if (!close) begin
            state_n = ST_TRACK;
            match_n = '0;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (timeout) begin
      state_n = ST_IDLE;
      match_n = '0;
    end

    // Evaluated on the values being registered so it changes with the strobe.
    note_n = (state_n == ST_LOCKED) && (abs_diff(prev_n, NOTE_C) <= TOL_C);
  end

  assign locked  = (state == ST_LOCKED);
  assign silence = (state == ST_IDLE);

endmodule

// File: tb/tb_tone_detector.sv
// Scoreboard bench for tone_detector with a scaled-down parameter set.
module tb_tone_detector;

  localparam int PW    = 11;
  localparam int MAX_P = 1500;
  localparam int TOL   = 6;
  localparam int LC    = 4;
  localparam int NOTE  = 568;
  localparam int W     = PW + 2;

  // ---------------- clock / reset ----------------
  logic clk        = 1'b0;
  logic rst_n      = 1'b0;
  logic speaker_in = 1'b0;

  logic [PW-1:0] period;
  logic          period_valid;
  logic          locked;
  logic          note_match;
  logic          silence;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tone_detector #(
    .PERIOD_W   (PW),
    .MAX_PERIOD (MAX_P),
    .TOL        (TOL),
    .LOCK_COUNT (LC),
    .NOTE_PERIOD(NOTE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .speaker_in  (speaker_in),
    .period      (period),
    .period_valid(period_valid),
    .locked      (locked),
    .note_match  (note_match),
    .silence     (silence)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model (event level) ----------------
  // {note_match, locked, period} per expected strobe, plus the drive cycle of
  // the rising edge that produced it.
  logic [W-1:0] exp_q[$];
  int           rc_q[$];

  int m_state       = 0;  // 0 idle, 1 armed, 2 track, 3 locked
  int m_prev        = 0;
  int m_mc          = 0;
  int m_last        = 0;
  bit m_have_last   = 1'b0;
  int m_last_period = 0;

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic publish(input int g, input int now);
    logic nt;
    logic lk;
    lk = (m_state == 3);
    nt = lk && (iabs(g - NOTE) <= TOL);
    exp_q.push_back({nt, lk, PW'(g)});
    rc_q.push_back(now);
    m_last_period = g;
  endtask

  task automatic model_rise();
    int now;
    int g;
    int d;
    now = cyc;
    g = m_have_last ? (now - m_last) : (MAX_P + 1);
    m_last      = now;
    m_have_last = 1'b1;
    if (m_state != 0 && g > MAX_P) begin
      m_state = 0;
      m_mc    = 0;
    end
    case (m_state)
      0: m_state = 1;
      1: begin
        m_prev  = g;
        m_mc    = 0;
        m_state = 2;
        publish(g, now);
      end
      2: begin
        d      = iabs(g - m_prev);
        m_prev = g;
        if (d <= TOL) begin
          m_mc++;
          if (m_mc == LC) begin
            m_state = 3;
            m_mc    = 0;
          end
        end else begin
          m_mc = 0;
        end
        publish(g, now);
      end
      default: begin
        d      = iabs(g - m_prev);
        m_prev = g;
        if (d > TOL) begin
          m_state = 2;
          m_mc    = 0;
        end
        publish(g, now);
      end
    endcase
  endtask

  task automatic model_reset();
    m_state     = 0;
    m_prev      = 0;
    m_mc        = 0;
    m_have_last = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; returns at a negedge, hi+lo cycles later.
  task automatic drive_cycle(input int hi, input int lo);
    speaker_in = 1'b1;
    model_rise();
    repeat (hi) @(negedge clk);
    speaker_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_silence"}, silence, 1);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_note"}, note_match, 0);
    check({tag, "_period"}, period, 0);
    check({tag, "_pv"}, period_valid, 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    int           rc;
    if (rst_n && period_valid) begin
      check("pulse_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        rc = rc_q.pop_front();
        check("period", period, e[PW-1:0]);
        check("locked", locked, e[PW]);
        check("note_match", note_match, e[PW+1]);
        check("latency", cyc - rc, 3);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t;
    rst_n      = 1'b0;
    speaker_in = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;
    repeat (2000) @(negedge clk);
    check("idle_silence", silence, 1);
    check("idle_period", period, 0);

    // A440-equivalent tone: arm, first period, four matches -> lock.
    repeat (8) drive_cycle(284, 284);
    check("a440_locked", locked, 1);
    check("a440_note", note_match, 1);
    check("a440_period", period, NOTE);

    // Tolerance boundaries: 574 (delta 6) stays locked, 580 loses note_match,
    // back to 568 (delta 12) drops lock, then four matches relock.
    drive_cycle(287, 287);
    drive_cycle(290, 290);
    repeat (6) drive_cycle(284, 284);
    check("relock_locked", locked, 1);

    // A 576 period (delta 8) drops the lock on that edge.
    drive_cycle(288, 288);
    drive_cycle(284, 284);
    check("drop_locked", locked, 0);
    check("drop_period", period, 576);
    repeat (5) drive_cycle(284, 284);
    check("relock2_locked", locked, 1);
    check("relock2_note", note_match, 1);

    // Input held low: timeout to IDLE, period retained.
    t = 0;
    while (!silence && t < MAX_P + 100) begin
      @(negedge clk);
      t++;
    end
    check("silence_delay", cyc - m_last, MAX_P + 3);
    check("silence_locked", locked, 0);
    check("silence_note", note_match, 0);
    check("silence_period", period, m_last_period);

    // Off-target tone locks without note_match.
    repeat (8) drive_cycle(250, 250);
    check("t500_locked", locked, 1);
    check("t500_note", note_match, 0);
    check("t500_period", period, 500);

    // A period of exactly MAX_PERIOD is published; one cycle more times out.
    repeat (3) drive_cycle(750, 750);
    drive_cycle(751, 750);
    check("max_period", period, MAX_P);
    repeat (3) drive_cycle(250, 250);
    check("after_timeout_period", period, 500);

    // Reset mid-lock, then the first edge only arms.
    repeat (7) drive_cycle(284, 284);
    check("prereset_locked", locked, 1);
    check("prereset_drained", exp_q.size(), 0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    drive_cycle(284, 284);
    check("post_rst_arm_period", period, 0);
    check("post_rst_arm_silence", silence, 0);
    repeat (2) drive_cycle(284, 284);
    check("post_rst_period", period, NOTE);

    repeat (10) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
